// File: rtl/dds_freq_meter.sv
// dds_freq_meter: counts f_in rising edges over a 2^GATE_LOG2 clk gate and reports them as a DDS tuning word.
// Define DDS_FMETER_CONT_EN for continuous back-to-back measurement instead of single-shot.
module dds_freq_meter #(
    parameter int GATE_LOG2 = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 f_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 meas_valid,
    output logic [31:0]          K_meas,
    output logic [GATE_LOG2-1:0] edge_cnt
);
    localparam int G = GATE_LOG2;
    typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;
`ifdef DDS_FMETER_CONT_EN
    localparam state_t AFTER_DONE = GATE;
`else
    localparam state_t AFTER_DONE = IDLE;
`endif
    state_t state, state_nx;
    logic s1, s2, dly, rise, last;
    logic [G-1:0] gate_cnt, acc, acc_nx;
    assign rise   = s2 & ~dly;
    assign last   = gate_cnt == '1;
    assign acc_nx = acc + G'(rise);
    always_comb begin
        state_nx   = state;
        state_nx   = (state == IDLE) ? (start ? GATE : IDLE) :
                     (state == GATE) ? (last ? DONE : GATE) : AFTER_DONE;
        busy       = state != IDLE;
        meas_valid = state == DONE;
    end
    // Results load on the final gate edge so they are already valid while meas_valid is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            dly      <= 1'b0;
            state    <= IDLE;
            gate_cnt <= '0;
            acc      <= '0;
            edge_cnt <= '0;
            K_meas   <= '0;
        end else begin
            s1    <= f_in;
            s2    <= s1;
            dly   <= s2;
            state <= state_nx;
            if (state == GATE) begin
                gate_cnt <= gate_cnt + G'(1);
                acc      <= acc_nx;
                if (last) begin
                    edge_cnt <= acc_nx;
                    K_meas   <= 32'(acc_nx) << (32 - G);
                end
            end else begin
                gate_cnt <= '0;
                acc      <= '0;
            end
        end
    end
endmodule
